// File: rtl/loopyv_mem_arbiter_pkg.sv
// Shared types for the LoopyV memory arbiter: FSM states, bus owner, bus request word.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package loopyV_data_types;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } MemArbStateType;

  // Which requester owns the single outstanding bus transaction.
  typedef enum logic {
    IF   = 1'b0,
    DATA = 1'b1
  } MemArbOwnerType;

  // Everything the bus needs for one request, held stable during ISSUE.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteEn;
  } MemBusReqType;

  localparam logic [3:0] FETCH_BYTE_EN = 4'hF;

  // A fetch is always a full-word read; the store data field is unused.
  function automatic MemBusReqType fetchBusReq(input logic [31:0] addr);
    MemBusReqType req;
    req.write  = 1'b0;
    req.addr   = addr;
    req.wdata  = 32'h0;
    req.byteEn = FETCH_BYTE_EN;
    return req;
  endfunction

endpackage

// File: rtl/loopyv_arb_grant.sv
// Grant decision between fetch and data requesters, with the fetch starvation counter.
// Latency: combinational grant; starveCnt updates on the accepting edge.
// Backpressure: grants only while idle is high; a requester not granted simply waits.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   idle               arbiter can accept a new request this cycle
//   ifReqValid         fetch request pending
//   memReqValid        data request pending
//   grantIf/grantData  one-hot (or zero) grant, used directly as the ready outputs
module loopyv_arb_grant
  import loopyV_data_types::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic ifReqValid,
  input  logic memReqValid,
  output logic grantIf,
  output logic grantData
);

  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_DATA_BURST);

  // Number of consecutive data grants made while a fetch was waiting.
  logic [SW-1:0] starveCnt;
  logic          forceIf;

  always_comb begin
    forceIf   = ifReqValid && (starveCnt == STARVE_MAX);
    grantData = idle && memReqValid && !forceIf;
    grantIf   = idle && ifReqValid && !grantData;
  end

  // Valid is already folded into the grant, so a grant is an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (grantData) begin
      if (!ifReqValid) begin
        starveCnt <= '0;
      end else if (starveCnt != STARVE_MAX) begin
        starveCnt <= starveCnt + 1'b1;
      end
    end else if (grantIf) begin
      starveCnt <= '0;
    end
  end

endmodule

// File: rtl/loopyv_mem_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store, one transaction at a time.
// Latency: accept at T, bus request from T+1, earliest response pulse and next accept at T+3.
// Backpressure: requester ready only in IDLE; bus request held until busReqReady; WAIT times out.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   ifReq*/ifResp*                fetch request (valid/ready) and one-cycle response pulse
//   memReq*/memResp*              load/store request (valid/ready) and one-cycle response pulse
//   busReq*                       bus request (valid/ready), fields stable while valid
//   busRespValid/busRespData      bus read data or write ack, honoured only in WAIT
module loopyv_mem_arbiter
  import loopyV_data_types::*;
#(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifReqValid,
  input  logic [31:0] ifReqAddr,
  output logic        ifReqReady,
  output logic        ifRespValid,
  output logic [31:0] ifRespData,
  output logic        ifRespErr,
  input  logic        memReqValid,
  input  logic        memReqWrite,
  input  logic [31:0] memReqAddr,
  input  logic [31:0] memReqWdata,
  input  logic [3:0]  memReqByteEn,
  output logic        memReqReady,
  output logic        memRespValid,
  output logic [31:0] memRespData,
  output logic        memRespErr,
  output logic        busReqValid,
  input  logic        busReqReady,
  output logic        busReqWrite,
  output logic [31:0] busReqAddr,
  output logic [31:0] busReqWdata,
  output logic [3:0]  busReqByteEn,
  input  logic        busRespValid,
  input  logic [31:0] busRespData
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  MemArbStateType state;
  MemArbOwnerType owner;
  MemBusReqType   busReq;
  logic [TW-1:0]  timeoutCnt;
  logic           grantIf;
  logic           grantData;

  loopyv_arb_grant #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) uGrant (
    .clk        (clk),
    .rst        (rst),
    .idle       (state == IDLE),
    .ifReqValid (ifReqValid),
    .memReqValid(memReqValid),
    .grantIf    (grantIf),
    .grantData  (grantData)
  );

  assign ifReqReady   = grantIf;
  assign memReqReady  = grantData;

  assign busReqWrite  = busReq.write;
  assign busReqAddr   = busReq.addr;
  assign busReqWdata  = busReq.wdata;
  assign busReqByteEn = busReq.byteEn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= DATA;
      busReq       <= '0;
      busReqValid  <= 1'b0;
      timeoutCnt   <= '0;
      ifRespValid  <= 1'b0;
      ifRespData   <= '0;
      ifRespErr    <= 1'b0;
      memRespValid <= 1'b0;
      memRespData  <= '0;
      memRespErr   <= 1'b0;
    end else begin
      // Response valids are single-cycle pulses.
      ifRespValid  <= 1'b0;
      memRespValid <= 1'b0;

      case (state)
        IDLE: begin
          if (grantData) begin
            busReq.write  <= memReqWrite;
            busReq.addr   <= memReqAddr;
            busReq.wdata  <= memReqWdata;
            busReq.byteEn <= memReqByteEn;
            owner         <= DATA;
            busReqValid   <= 1'b1;
            state         <= ISSUE;
          end else if (grantIf) begin
            busReq      <= fetchBusReq(ifReqAddr);
            owner       <= IF;
            busReqValid <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          // No timeout here: the bus may stall acceptance indefinitely.
          if (busReqReady) begin
            busReqValid <= 1'b0;
            timeoutCnt  <= '0;
            state       <= WAIT;
          end
        end

        WAIT: begin
          // A response arriving on the last allowed cycle beats the timeout.
          if (busRespValid || (timeoutCnt == TIMEOUT_LAST)) begin
            if (owner == IF) begin
              ifRespValid <= 1'b1;
              ifRespData  <= busRespValid ? busRespData : 32'h0;
              ifRespErr   <= !busRespValid;
            end else begin
              memRespValid <= 1'b1;
              memRespData  <= busRespValid ? busRespData : 32'h0;
              memRespErr   <= !busRespValid;
            end
            state <= IDLE;
          end else begin
            timeoutCnt <= timeoutCnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loopyv_mem_arbiter.sv
// Self-checking bench for loopyv_mem_arbiter: directed scenarios plus random transactions.
// Latency: n/a (testbench).
// Backpressure: bench plays both requesters and the bus, with random bus stalls and timeouts.
module tb_loopyv_mem_arbiter;

  localparam int MAXB = 4;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifReqValid = 1'b0;
  logic [31:0] ifReqAddr = '0;
  logic        ifReqReady;
  logic        ifRespValid;
  logic [31:0] ifRespData;
  logic        ifRespErr;
  logic        memReqValid = 1'b0;
  logic        memReqWrite = 1'b0;
  logic [31:0] memReqAddr = '0;
  logic [31:0] memReqWdata = '0;
  logic [3:0]  memReqByteEn = '0;
  logic        memReqReady;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        memRespErr;
  logic        busReqValid;
  logic        busReqReady = 1'b0;
  logic        busReqWrite;
  logic [31:0] busReqAddr;
  logic [31:0] busReqWdata;
  logic [3:0]  busReqByteEn;
  logic        busRespValid = 1'b0;
  logic [31:0] busRespData = '0;

  loopyv_mem_arbiter #(.MAX_DATA_BURST(MAXB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifReqValid(ifReqValid), .ifReqAddr(ifReqAddr), .ifReqReady(ifReqReady),
    .ifRespValid(ifRespValid), .ifRespData(ifRespData), .ifRespErr(ifRespErr),
    .memReqValid(memReqValid), .memReqWrite(memReqWrite), .memReqAddr(memReqAddr),
    .memReqWdata(memReqWdata), .memReqByteEn(memReqByteEn), .memReqReady(memReqReady),
    .memRespValid(memRespValid), .memRespData(memRespData), .memRespErr(memRespErr),
    .busReqValid(busReqValid), .busReqReady(busReqReady), .busReqWrite(busReqWrite),
    .busReqAddr(busReqAddr), .busReqWdata(busReqWdata), .busReqByteEn(busReqByteEn),
    .busRespValid(busRespValid), .busRespData(busRespData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } busExpT;

  typedef struct {
    bit          isIf;
    logic [31:0] data;
    bit          err;
    int          when;
  } respExpT;

  busExpT  busQ[$];
  respExpT respQ[$];

  int checkCnt = 0;
  int passCnt  = 0;

  // Reference model state: consecutive data grants while a fetch was waiting.
  int dataRun = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change 2 time units after the rising edge; the monitor samples on the falling edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  respExpT     r;
  busExpT      b;
  logic        prevValid = 1'b0;
  logic        prevReady = 1'b0;
  logic [68:0] prevFields = '0;

  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (ifRespValid || memRespValid) begin
        if (respQ.size() == 0) begin
          check("unexpectedResp", {ifRespValid, memRespValid}, 2'b00);
        end else begin
          r = respQ.pop_front();
          check("respPort", {ifRespValid, memRespValid}, r.isIf ? 2'b10 : 2'b01);
          check("respData", r.isIf ? ifRespData : memRespData, r.data);
          check("respErr", r.isIf ? ifRespErr : memRespErr, r.err);
          check("respCycle", cyc, r.when);
        end
      end
      if (ifReqReady || memReqReady)
        check("oneReady", ifReqReady & memReqReady, 1'b0);
      if (prevValid && !prevReady && busReqValid)
        check("busStable", {busReqWrite, busReqAddr, busReqWdata, busReqByteEn}, prevFields);
      if (busReqValid && busReqReady) begin
        if (busQ.size() == 0) begin
          check("unexpectedBusReq", busReqValid, 1'b0);
        end else begin
          b = busQ.pop_front();
          check("busWrite", busReqWrite, b.wr);
          check("busAddr", busReqAddr, b.addr);
          check("busByteEn", busReqByteEn, b.be);
          if (b.wr) check("busWdata", busReqWdata, b.wdata);
        end
      end
      prevValid  = busReqValid;
      prevReady  = busReqReady;
      prevFields = {busReqWrite, busReqAddr, busReqWdata, busReqByteEn};
    end
  end

  // ---------------- driver ----------------
  // Called in an IDLE cycle; returns in the cycle the response pulse is visible.
  task automatic runTxn(input bit ifV, input bit memV, input bit hold,
                        input bit mWr, input logic [31:0] iAddr, input logic [31:0] mAddr,
                        input logic [31:0] wdat, input logic [3:0] be,
                        input int rdyDly, input int rspDly, input logic [31:0] rdat,
                        output bit gotData);
    bit      gd;
    int      w;
    respExpT re;
    busExpT  be_;
    gd = memV && !(ifV && dataRun == MAXB);
    ifReqValid   = ifV;
    ifReqAddr    = iAddr;
    memReqValid  = memV;
    memReqWrite  = mWr;
    memReqAddr   = mAddr;
    memReqWdata  = wdat;
    memReqByteEn = be;
    #1;
    gotData = memReqReady;
    check("ifReady", ifReqReady, ifV && !gd);
    check("memReady", memReqReady, gd);
    if (gd) begin
      be_.wr = mWr; be_.addr = mAddr; be_.wdata = wdat; be_.be = be;
      dataRun = ifV ? ((dataRun < MAXB) ? dataRun + 1 : MAXB) : 0;
    end else begin
      be_.wr = 1'b0; be_.addr = iAddr; be_.wdata = '0; be_.be = 4'hF;
      dataRun = 0;
    end
    busQ.push_back(be_);
    tick();
    if (!hold) begin
      ifReqValid  = 1'b0;
      memReqValid = 1'b0;
    end
    for (int i = 0; i < rdyDly; i++) tick();
    busReqReady = 1'b1;
    #1;
    check("busValid", busReqValid, 1'b1);
    tick();
    busReqReady = 1'b0;
    w = cyc;
    re.isIf = !gd;
    if (rspDly < TO) begin
      re.data = rdat; re.err = 1'b0; re.when = w + rspDly + 1;
      respQ.push_back(re);
      for (int i = 0; i < rspDly; i++) tick();
      busRespValid = 1'b1;
      busRespData  = rdat;
      tick();
      busRespValid = 1'b0;
      busRespData  = $urandom;
    end else begin
      re.data = '0; re.err = 1'b1; re.when = w + TO;
      respQ.push_back(re);
      while (cyc < w + TO) tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit       gd;
    bit [9:0] order;
    respExpT  dummy;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    // Reset state.
    check("rstReady", {ifReqReady, memReqReady}, 2'b00);
    check("rstIfResp", {ifRespValid, ifRespData, ifRespErr}, 34'h0);
    check("rstMemResp", {memRespValid, memRespData, memRespErr}, 34'h0);
    check("rstBus", {busReqValid, busReqWrite, busReqAddr, busReqWdata, busReqByteEn}, 70'h0);

    // Fetch only.
    runTxn(1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, gd);

    // Simultaneous: data first, fetch next.
    runTxn(1, 1, 0, 0, 32'h200, 32'h8000, 32'h0, 4'hF, 0, 0, 32'hA5A50001, gd);
    runTxn(1, 0, 0, 0, 32'h200, 32'h0, 32'h0, 4'h0, 0, 1, 32'hA5A50002, gd);

    // Starvation guard with both requesters held high.
    for (int i = 0; i < 10; i++) begin
      runTxn(1, 1, 1, 0, 32'h1000 + i * 4, 32'h2000 + i * 4, 32'h0, 4'hF,
             0, 0, 32'hC0DE0000 + i, gd);
      order[9-i] = gd;
    end
    check("starveOrder", order, 10'b1111011110);
    ifReqValid = 0; memReqValid = 0;

    // Store with bus stalled for 3 cycles.
    runTxn(0, 1, 0, 1, 32'h0, 32'h40, 32'h12345678, 4'b0011, 3, 1, 32'h0, gd);

    // Timeout, then a late response while idle.
    runTxn(0, 1, 0, 0, 32'h0, 32'h44, 32'h0, 4'hF, 0, 99, 32'h0, gd);
    busRespValid = 1'b1;
    busRespData  = 32'hBAD0BAD0;
    tick();
    busRespValid = 1'b0;
    repeat (3) tick();

    // Reset while waiting for a bus response.
    ifReqValid = 1'b1;
    ifReqAddr  = 32'h300;
    dummy.isIf = 1'b1;
    busQ.push_back('{wr: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'hF});
    tick();
    ifReqValid  = 1'b0;
    busReqReady = 1'b1;
    tick();
    busReqReady = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("midRstBusValid", busReqValid, 1'b0);
    check("midRstResp", {ifRespValid, memRespValid, ifReqReady, memReqReady}, 4'h0);
    dataRun = 0;
    tick();
    rst = 1'b0;
    tick();
    busRespValid = 1'b1;
    busRespData  = 32'h5555AAAA;
    tick();
    busRespValid = 1'b0;
    repeat (3) tick();
    runTxn(1, 0, 0, 0, 32'h400, 32'h0, 32'h0, 4'h0, 1, 2, 32'h0BADF00D, gd);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      bit iv, mv;
      iv = 1'($urandom);
      mv = 1'($urandom);
      if (!iv && !mv) iv = 1'b1;
      runTxn(iv, mv, 0, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 10), $urandom, gd);
    end

    repeat (5) tick();
    check("respQueueDrained", respQ.size(), 0);
    check("busQueueDrained", busQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/loopyv_mem_arbiter.md
Name: loopyv_mem_arbiter

Overview:
- Shares a single memory bus port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between both pipeline stages and the core's external memory bus.
- Allows one outstanding bus transaction at a time.
- Data requests have priority, with a starvation guard for fetch and a per-transaction response timeout.

Parameters:
- MAX_DATA_BURST, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced through.
- TIMEOUT_CYCLES, 64: cycles in WAIT without a bus response before an error response is returned.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ifReqValid  in  1  fetch request.
- ifReqAddr  in  32  fetch address.
- ifReqReady  out  1  fetch request accepted this cycle.
- ifRespValid  out  1  fetch response, one-cycle pulse.
- ifRespData  out  32  fetched word.
- ifRespErr  out  1  fetch timed out.
- memReqValid  in  1  data request.
- memReqWrite  in  1  1 = store, 0 = load.
- memReqAddr  in  32  data address.
- memReqWdata  in  32  store data.
- memReqByteEn  in  4  byte enables.
- memReqReady  out  1  data request accepted.
- memRespValid  out  1  data response pulse; also the store ack.
- memRespData  out  32  load data.
- memRespErr  out  1  data access timed out.
- busReqValid  out  1  bus request.
- busReqReady  in  1  bus accepts request.
- busReqWrite  out  1  write request.
- busReqAddr  out  32  bus address.
- busReqWdata  out  32  bus write data.
- busReqByteEn  out  4  bus byte enables; 4'hF for fetches.
- busRespValid  in  1  read data valid or write ack.
- busRespData  in  32  read data.

Behaviour:
- Reset: all outputs are 0. state = IDLE, starveCnt = 0, timeoutCnt = 0, owner = DATA.
- States: IDLE, ISSUE, WAIT.
- IDLE, grant decision (combinational):
  - If memReqValid and not (ifReqValid and starveCnt == MAX_DATA_BURST), grant DATA.
  - Else if ifReqValid, grant IF.
  - The selected ready is high only in IDLE; at most one ready is high per cycle.
- On accept (valid & ready at edge T):
  - Register addr, wdata, byteEn and write into the bus request registers; a fetch forces write = 0 and byteEn = 4'hF.
  - Record owner and go to ISSUE.
  - busReqValid = 1 from T+1.
- ISSUE:
  - Hold busReqValid and all bus request fields stable until busReqReady is sampled high.
  - Then drop busReqValid and go to WAIT with timeoutCnt = 0.
  - There is no timeout in ISSUE.
- WAIT:
  - timeoutCnt increments each cycle.
  - On busRespValid, the next cycle pulses the owner's respValid for one cycle, with respData = busRespData and respErr = 0; state goes to IDLE.
  - If timeoutCnt == TIMEOUT_CYCLES-1 without busRespValid, pulse the owner's respValid with respErr = 1 and respData = 0; go to IDLE.
  - busRespValid and the timeout in the same cycle: the response wins, err = 0.
- busRespValid outside WAIT is discarded; this covers late responses after a timeout.
- The non-owner's respValid is never asserted.
- Latency: the earliest response is at T+3 (busReqReady at T+1, busRespValid at T+2). The earliest next accept is at T+3.
- starveCnt, updated only on a grant:
  - DATA grant with ifReqValid = 1: increment, saturating at MAX_DATA_BURST.
  - DATA grant with ifReqValid = 0: clear to 0.
  - IF grant: clear to 0.
- Requester inputs are sampled only at accept; changes afterwards have no effect.
- A requester that drops valid before accept is legal and produces no transaction.
- Reset asserted mid-transaction: return to IDLE immediately, no response pulse, busReqValid deasserts asynchronously.

Decomposition:
- Add to package loopyV_data_types:
  - MemArbStateType: enum of IDLE/ISSUE/WAIT.
  - MemArbOwnerType: enum of IF/DATA.
  - MemBusReqType: packed struct of write, addr[31:0], wdata[31:0], byteEn[3:0].
- Sub-module loopyv_arb_grant holds the grant decision and the starveCnt register; loopyv_mem_arbiter holds the FSM, request registers and timeout counter.

Test Plan:
1. Fetch only: ifReqAddr=0x100, bus ready at once, busRespData=0xDEADBEEF 2 cycles later -> busReqByteEn=4'hF, busReqWrite=0; ifRespValid pulses 1 cycle with 0xDEADBEEF; memRespValid stays 0.
2. Simultaneous requests: ifReqAddr=0x200, memReqAddr=0x8000 load -> memReqReady first; bus sees 0x8000, then 0x200; responses are routed to the correct requester.
3. Starvation guard, MAX_DATA_BURST=4: memReqValid and ifReqValid held high continuously -> grant order DATA×4, IF, DATA×4, IF.
4. Store handshake: memReqWrite=1, addr 0x40, wdata 0x12345678, byteEn 4'b0011, busReqReady low for 3 cycles -> bus fields stable for all 3 cycles; memRespValid on ack with memRespErr=0.
5. Timeout, TIMEOUT_CYCLES=8: no busRespValid -> memRespValid with memRespErr=1 and data 0, 8 cycles after entering WAIT; a late busRespValid in IDLE produces no response.
6. Reset in WAIT, then a new fetch -> no response pulse; outputs are 0; the next fetch completes normally.
